controlador_terminais: RTL and testbench
========================================

Name: controlador_terminais

Overview:
- Responder side of the terminal-selection interface. It takes the per-terminal enables produced by the terminal selector, plus request and done handshakes from the two terminals.
- Grants the shared resource to one enabled terminal at a time. Arbitration is round-robin, each grant has a hold timeout, and there is a mandatory one-cycle release gap between grants.
- Sits between the combinational terminal selector and the terminal front-ends.

Parameters:
- HOLD_CYCLES, 8, maximum grant length in clock cycles before forced timeout; legal range 1..(2^CNT_W - 1).
- CNT_W, 4, width of the internal hold counter.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- EN1  in  1  terminal 1 enabled (selector TERMINAL1 output).
- EN2  in  1  terminal 2 enabled (selector TERMINAL2 output).
- REQ1  in  1  terminal 1 request; held high until granted or withdrawn.
- REQ2  in  1  terminal 2 request.
- DONE1  in  1  terminal 1 finished; sampled only while GNT1=1.
- DONE2  in  1  terminal 2 finished; sampled only while GNT2=1.
- GNT1  out  1  registered grant to terminal 1.
- GNT2  out  1  registered grant to terminal 2.
- BUSY  out  1  registered; high in any state other than IDLE.
- TIMEOUT  out  1  registered one-cycle pulse when a grant ended by counter expiry.
- LAST  out  1  registered; 0 = terminal 1 was served last, 1 = terminal 2 was served last.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - state=IDLE; GNT1=GNT2=BUSY=TIMEOUT=0; LAST=1, so terminal 1 wins the first tie; counter=0.
  - Reset asserted mid-grant drops the grant immediately with no release cycle.
- Candidates: Ci = REQi & ENi.
- FSM states: IDLE, GRANT1, GRANT2, RELEASE.
- IDLE:
  - Only C1 high: go to GRANT1 at the same edge.
  - Only C2 high: go to GRANT2 at the same edge.
  - C1 and C2 both high: grant the terminal that is not LAST (round-robin).
  - Neither high: stay in IDLE.
  - On entry to GRANTi: GNTi=1, BUSY=1, counter=HOLD_CYCLES, LAST updated to i.
- Latency: GNTi is visible from the first edge at which IDLE samples Ci=1, i.e. 1 cycle after the request.
- GRANTi: at each edge evaluate these exit causes in priority order:
  - DONEi=1 → normal completion.
  - REQi=0 or ENi=0 → withdrawal.
  - counter==1 → timeout; set TIMEOUT=1 for the next cycle.
  - None of the above: counter decrements and the state holds.
  - Any exit goes to RELEASE and clears GNTi.
  - Maximum GNTi high time is exactly HOLD_CYCLES cycles.
- DONEi and expiry on the same edge: counts as completion, TIMEOUT stays 0.
- RELEASE:
  - Lasts exactly 1 cycle; GNT1=GNT2=0, BUSY=1.
  - Next state is IDLE. Requests are not evaluated in RELEASE.
  - TIMEOUT (if set) is high only during this cycle.
- The other terminal's REQ/DONE/EN changes while one terminal is granted are ignored. GNT1 and GNT2 are never high together.
- A request held continuously after its own grant ends is re-granted only if the other terminal is not a candidate in IDLE.

Optional Feature:
- Macro SERVICE_COUNT_EN.
- When defined:
  - Adds outputs SERV1 and SERV2, each 8 bits, registered.
  - SERVi increments by 1 at the edge GRANTi→RELEASE when the exit cause is DONEi. Timeouts and withdrawals do not count.
  - Saturates at 255; reset to 0 by RST_N.
- When undefined: those ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset release, EN1=1, REQ1=1 at cycle 0 → GNT1=1 from edge 1, BUSY=1, LAST=0; DONE1=1 at edge 4 → GNT1=0 at edge 4, RELEASE for 1 cycle, BUSY=0 at edge 5, TIMEOUT never high.
- EN1=EN2=1, REQ1=REQ2 held high, DONE pulsed each grant → grants alternate GNT1, GNT2, GNT1, GNT2, with exactly one idle-grant gap (RELEASE) between each.
- HOLD_CYCLES=8, REQ2=1, EN2=1, DONE2=0 → GNT2 high exactly 8 cycles, TIMEOUT=1 for the single following cycle, then back to IDLE.
- REQ1=1 with EN1=0 → no grant, BUSY=0; drop EN1 to 0 mid-grant on edge 3 → GNT1=0 on edge 3, RELEASE follows.
- Pull RST_N low mid-GRANT2 between edges → GNT2, BUSY fall immediately; after release LAST=1, so simultaneous REQ1/REQ2 grants terminal 1.
- SERVICE_COUNT_EN: 3 completions plus 1 timeout on terminal 1 → SERV1=3. Force 300 completions → SERV1=255.

Source files
------------

// File: rtl/controlador_terminais.sv
// Round-robin grant controller for two terminals with hold timeout and a one-cycle release gap.
// Optional per-terminal completion counters (SERV1/SERV2) are built when SERVICE_COUNT_EN is defined.
module controlador_terminais #(
  parameter int HOLD_CYCLES = 8,
  parameter int CNT_W       = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       EN1,
  input  logic       EN2,
  input  logic       REQ1,
  input  logic       REQ2,
  input  logic       DONE1,
  input  logic       DONE2,
  output logic       GNT1,
  output logic       GNT2,
  output logic       BUSY,
  output logic       TIMEOUT,
  output logic       LAST
`ifdef SERVICE_COUNT_EN
  ,
  output logic [7:0] SERV1,
  output logic [7:0] SERV2
`endif
);

  typedef enum logic [1:0] {IDLE, GRANT1, GRANT2, RELEASE} state_t;

  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q;
  logic             gnt1_q, gnt2_q, busy_q, timeout_q, last_q;
  logic [CNT_W-1:0] cnt_q;
  logic             c1, c2;

`ifdef SERVICE_COUNT_EN
  logic [7:0] serv1_q, serv2_q;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
`endif

  assign c1 = REQ1 & EN1;
  assign c2 = REQ2 & EN2;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      gnt1_q    <= 1'b0;
      gnt2_q    <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      last_q    <= 1'b1;
      cnt_q     <= '0;
`ifdef SERVICE_COUNT_EN
      serv1_q   <= 8'd0;
      serv2_q   <= 8'd0;
`endif
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // On a tie, the terminal not served last wins.
          if (c1 && (!c2 || last_q)) begin
            state_q <= GRANT1;
            gnt1_q  <= 1'b1;
            busy_q  <= 1'b1;
            cnt_q   <= HOLD_INIT;
            last_q  <= 1'b0;
          end else if (c2) begin
            state_q <= GRANT2;
            gnt2_q  <= 1'b1;
            busy_q  <= 1'b1;
            cnt_q   <= HOLD_INIT;
            last_q  <= 1'b1;
          end
        end
        GRANT1: begin
          if (DONE1 || !c1 || cnt_q == CNT_ONE) begin
            state_q   <= RELEASE;
            gnt1_q    <= 1'b0;
            timeout_q <= !DONE1 && c1;
`ifdef SERVICE_COUNT_EN
            if (DONE1) serv1_q <= sat_inc(serv1_q);
`endif
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        GRANT2: begin
          if (DONE2 || !c2 || cnt_q == CNT_ONE) begin
            state_q   <= RELEASE;
            gnt2_q    <= 1'b0;
            timeout_q <= !DONE2 && c2;
`ifdef SERVICE_COUNT_EN
            if (DONE2) serv2_q <= sat_inc(serv2_q);
`endif
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        RELEASE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          gnt1_q  <= 1'b0;
          gnt2_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign GNT1    = gnt1_q;
  assign GNT2    = gnt2_q;
  assign BUSY    = busy_q;
  assign TIMEOUT = timeout_q;
  assign LAST    = last_q;
`ifdef SERVICE_COUNT_EN
  assign SERV1   = serv1_q;
  assign SERV2   = serv2_q;
`endif

endmodule

// File: tb/tb_controlador_terminais.sv
// Directed bench for controlador_terminais: reset, round-robin, timeout, withdrawal, async reset,
// and (with SERVICE_COUNT_EN) the saturating completion counters.
module tb_controlador_terminais;

  logic CLK = 1'b0;
  logic RST_N, EN1, EN2, REQ1, REQ2, DONE1, DONE2;
  logic GNT1, GNT2, BUSY, TIMEOUT, LAST;
`ifdef SERVICE_COUNT_EN
  logic [7:0] SERV1, SERV2;
`endif

  int checks = 0;
  int errors = 0;

  controlador_terminais #(.HOLD_CYCLES(8), .CNT_W(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .EN1(EN1), .EN2(EN2), .REQ1(REQ1), .REQ2(REQ2),
    .DONE1(DONE1), .DONE2(DONE2), .GNT1(GNT1), .GNT2(GNT2), .BUSY(BUSY),
    .TIMEOUT(TIMEOUT), .LAST(LAST)
`ifdef SERVICE_COUNT_EN
    , .SERV1(SERV1), .SERV2(SERV2)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    EN1 = 0; EN2 = 0; REQ1 = 0; REQ2 = 0; DONE1 = 0; DONE2 = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST_N = 0;
    step();
    step();
    RST_N = 1;
  endtask

  initial begin
    do_reset();
    chk("rst_gnt1", GNT1, 0);
    chk("rst_gnt2", GNT2, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_tmo", TIMEOUT, 0);
    chk("rst_last", LAST, 1);

    // Single request on terminal 1, completed at edge 4.
    EN1 = 1; REQ1 = 1;
    step();
    chk("t1_gnt1_e1", GNT1, 1);
    chk("t1_busy_e1", BUSY, 1);
    chk("t1_last_e1", LAST, 0);
    step();
    step();
    chk("t1_gnt1_e3", GNT1, 1);
    DONE1 = 1;
    step();
    chk("t1_gnt1_e4", GNT1, 0);
    chk("t1_busy_e4", BUSY, 1);
    chk("t1_tmo_e4", TIMEOUT, 0);
    DONE1 = 0; REQ1 = 0;
    step();
    chk("t1_busy_e5", BUSY, 0);
    chk("t1_tmo_e5", TIMEOUT, 0);

    // Both requesting: LAST=0 so terminal 2 goes first, then alternate.
    EN1 = 1; EN2 = 1; REQ1 = 1; REQ2 = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_gnt1", GNT1, (i % 2 == 1) ? 1 : 0);
      chk("rr_gnt2", GNT2, (i % 2 == 0) ? 1 : 0);
      if (i % 2 == 0) DONE2 = 1; else DONE1 = 1;
      step();
      chk("rr_rel_gnt", {GNT1, GNT2}, 0);
      chk("rr_rel_busy", BUSY, 1);
      DONE1 = 0; DONE2 = 0;
      step();
      chk("rr_idle_gnt", {GNT1, GNT2}, 0);
      chk("rr_idle_busy", BUSY, 0);
    end
    idle_inputs();

    // Timeout on terminal 2: 8 cycles of grant, then one TIMEOUT cycle.
    EN2 = 1; REQ2 = 1;
    step();
    chk("to_gnt2_first", GNT2, 1);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("to_gnt2_hold", GNT2, 1);
      chk("to_tmo_low", TIMEOUT, 0);
    end
    step();
    chk("to_gnt2_end", GNT2, 0);
    chk("to_tmo_pulse", TIMEOUT, 1);
    chk("to_busy_rel", BUSY, 1);
    REQ2 = 0;
    step();
    chk("to_tmo_clear", TIMEOUT, 0);
    chk("to_busy_idle", BUSY, 0);
    idle_inputs();

    // Request without enable, then enable dropped mid-grant.
    REQ1 = 1; EN1 = 0;
    step();
    step();
    chk("en0_gnt1", GNT1, 0);
    chk("en0_busy", BUSY, 0);
    EN1 = 1;
    step();
    chk("wd_gnt1_e1", GNT1, 1);
    step();
    EN1 = 0;
    step();
    chk("wd_gnt1_e3", GNT1, 0);
    chk("wd_busy_e3", BUSY, 1);
    chk("wd_tmo_e3", TIMEOUT, 0);
    step();
    chk("wd_busy_idle", BUSY, 0);
    idle_inputs();

    // DONE coinciding with counter expiry counts as completion.
    EN1 = 1; REQ1 = 1;
    step();
    chk("dx_gnt1", GNT1, 1);
    for (int i = 0; i < 7; i++) step();
    chk("dx_gnt1_hold", GNT1, 1);
    DONE1 = 1;
    step();
    chk("dx_gnt1_end", GNT1, 0);
    chk("dx_tmo", TIMEOUT, 0);
    idle_inputs();
    step();

    // Asynchronous reset in the middle of a terminal 2 grant.
    EN2 = 1; REQ2 = 1;
    step();
    chk("ar_gnt2", GNT2, 1);
    chk("ar_last", LAST, 1);
    step();
    #2;
    RST_N = 0;
    #1;
    chk("ar_gnt2_drop", GNT2, 0);
    chk("ar_busy_drop", BUSY, 0);
    chk("ar_last_rst", LAST, 1);
    #1;
    RST_N = 1;
    EN1 = 1; REQ1 = 1;
    step();
    chk("ar_tie_gnt1", GNT1, 1);
    chk("ar_tie_gnt2", GNT2, 0);
    idle_inputs();

`ifdef SERVICE_COUNT_EN
    do_reset();
    chk("sv_rst", SERV1, 0);
    EN1 = 1; REQ1 = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      DONE1 = 1;
      step();
      DONE1 = 0;
      step();
    end
    step();
    for (int i = 0; i < 8; i++) step();
    chk("sv_timeout_pulse", TIMEOUT, 1);
    REQ1 = 0;
    step();
    chk("sv_serv1_3", SERV1, 3);
    chk("sv_serv2_0", SERV2, 0);
    REQ1 = 1;
    for (int i = 0; i < 300; i++) begin
      step();
      DONE1 = 1;
      step();
      DONE1 = 0;
      step();
    end
    chk("sv_serv1_sat", SERV1, 255);
    idle_inputs();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
